// File: rtl/vga_scan_driver.sv
// Scan-side raster timing master: drives frame-buffer read address (x, y) and produces
// VGA RGB/sync pins two clocks later, aligned with the one-clock colour read latency.
module vga_scan_driver #(
  parameter int unsigned H_VISIBLE = 800,
  parameter int unsigned H_FRONT   = 40,
  parameter int unsigned H_SYNC    = 128,
  parameter int unsigned H_BACK    = 88,
  parameter int unsigned V_VISIBLE = 600,
  parameter int unsigned V_FRONT   = 1,
  parameter int unsigned V_SYNC    = 4,
  parameter int unsigned V_BACK    = 23,
  parameter bit          SYNC_POL  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [10:0] x,
  output logic [9:0]  y,
  input  logic [11:0] colour_in,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_trig,
  output logic        in_vblank,
  output logic [15:0] frame_count
);

  localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] HVis    = 11'(H_VISIBLE);
  localparam logic [10:0] HSyncLo = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HSyncHi = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] HLast   = 11'(HTotal - 1);
  localparam logic [9:0]  VVis    = 10'(V_VISIBLE);
  localparam logic [9:0]  VSyncLo = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VSyncHi = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0]  VLast   = 10'(VTotal - 1);

  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic        active_q, active_d;
  logic        hs_raw_q, hs_raw_d;
  logic        vs_raw_q, vs_raw_d;
  logic        vblank_q, vblank_d;
  logic        trig_q, trig_d;
  logic [15:0] fc_q, fc_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;

  always_comb begin
    h_d      = '0;
    v_d      = '0;
    active_d = 1'b0;
    hs_raw_d = 1'b0;
    vs_raw_d = 1'b0;
    vblank_d = 1'b0;
    trig_d   = 1'b0;
    fc_d     = fc_q;
    // With en low the raster parks at the origin and stage 1 decodes as blank.
    if (en) begin
      if (h_q == HLast) begin
        h_d = '0;
        v_d = (v_q == VLast) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 11'd1;
        v_d = v_q;
      end
      active_d = (h_q < HVis) && (v_q < VVis);
      hs_raw_d = (h_q >= HSyncLo) && (h_q < HSyncHi);
      vs_raw_d = (v_q >= VSyncLo) && (v_q < VSyncHi);
      vblank_d = (v_q >= VVis);
      trig_d   = (h_q == '0) && (v_q == VVis);
      if (trig_d) begin
        fc_d = fc_q + 16'd1;
      end
    end
    // colour_in now belongs to the address that produced active_q.
    rgb_d = active_q ? colour_in : 12'h000;
    hs_d  = hs_raw_q ^ ~SYNC_POL;
    vs_d  = vs_raw_q ^ ~SYNC_POL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q      <= '0;
      v_q      <= '0;
      active_q <= 1'b0;
      hs_raw_q <= 1'b0;
      vs_raw_q <= 1'b0;
      vblank_q <= 1'b0;
      trig_q   <= 1'b0;
      fc_q     <= '0;
      rgb_q    <= '0;
      hs_q     <= ~SYNC_POL;
      vs_q     <= ~SYNC_POL;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      active_q <= active_d;
      hs_raw_q <= hs_raw_d;
      vs_raw_q <= vs_raw_d;
      vblank_q <= vblank_d;
      trig_q   <= trig_d;
      fc_q     <= fc_d;
      rgb_q    <= rgb_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
    end
  end

  assign x           = h_q;
  assign y           = v_q;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign frame_trig  = trig_q;
  assign in_vblank   = vblank_q;
  assign frame_count = fc_q;

endmodule

// File: doc/vga_scan_driver.md
Name: vga_scan_driver

Overview:
- Scan-side timing master for the pixel frame buffer. Generates the horizontal and vertical raster counters and drives them as the read address (x, y) into the frame buffer.
- Takes the 12-bit colour back with one cycle of read latency and produces pipeline-aligned VGA RGB and sync outputs.
- Emits the per-frame trigger and vblank status consumed by the bus side.

Parameters:
- H_VISIBLE, 800, active pixels per line
- H_FRONT, 40, horizontal front porch (clocks)
- H_SYNC, 128, hsync pulse width (clocks)
- H_BACK, 88, horizontal back porch (clocks)
- V_VISIBLE, 600, active lines per frame
- V_FRONT, 1, vertical front porch (lines)
- V_SYNC, 4, vsync pulse width (lines)
- V_BACK, 23, vertical back porch (lines)
- SYNC_POL, 1, sync active level (1 = active-high)

Ports:
- clk  in  1  pixel clock (40 MHz for 800x600@60)
- rst  in  1  asynchronous, active-low reset
- en  in  1  scan enable; low holds the raster at origin and blanks the outputs
- x  out  11  frame-buffer read column (h counter)
- y  out  10  frame-buffer read row (v counter)
- colour_in  in  12  frame-buffer data; valid one clk after x/y
- vga_r  out  4  red output
- vga_g  out  4  green output
- vga_b  out  4  blue output
- vga_hs  out  1  hsync
- vga_vs  out  1  vsync
- frame_trig  out  1  one-cycle pulse at start of vblank
- in_vblank  out  1  high while v counter >= V_VISIBLE
- frame_count  out  16  completed-frame counter, wraps

Behaviour:
- Totals: H_TOTAL = sum of the H params = 1056; V_TOTAL = sum of the V params = 628.
- Reset (rst=0, async) values:
  - h_cnt, v_cnt, all pipeline registers and frame_count = 0.
  - RGB = 0, frame_trig = 0, in_vblank = 0.
  - hs/vs at the inactive level (~SYNC_POL).
- Reset release: counting starts on the first clk edge with rst=1 and en=1.
- Stage 0 (counters), when en=1:
  - h_cnt increments each clk and wraps H_TOTAL-1 -> 0.
  - On that wrap, v_cnt increments and wraps V_TOTAL-1 -> 0.
  - x = h_cnt and y = v_cnt, driven directly from the registers.
- Stage 1 (one clk later): registers from the stage-0 values:
  - active = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE)
  - hs_raw = h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC)
  - vs_raw = v_cnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC)
- Stage 2 (output):
  - RGB = active_d1 ? colour_in : 0, with colour_in split as {r[11:8], g[7:4], b[3:0]}.
  - vga_hs = hs_raw_d1 XNOR SYNC_POL-inverted, i.e. at the active level when hs_raw_d1 is set.
  - vga_vs is formed the same way from vs_raw_d1.
  - Total pixel latency from x/y to pins = 2 clk. RGB and syncs must be aligned.
- x and y range over the full totals during blanking. The frame buffer may read garbage then; it is masked by active.
- frame_trig:
  - Single-clk pulse registered in the cycle after the counters reach (h=0, v=V_VISIBLE).
  - Exactly one pulse per frame.
- frame_count increments on the same cycle frame_trig is asserted; wraps 0xFFFF -> 0.
- in_vblank = registered (v_cnt >= V_VISIBLE), in the same stage-1 timing as active.
- en deasserted mid-frame:
  - Next clk: counters reset to 0, stage-1 registers forced inactive.
  - Outputs blank/inactive within 2 clk.
  - frame_count holds.
  - No frame_trig while en=0.
- en reasserted: scan restarts at (0,0).
- frame_trig fires at the first v=V_VISIBLE only after a full visible region has been scanned.
- Async reset mid-line: all state clears immediately, with no glitch pulse on frame_trig.
- Parameter constraint: H_TOTAL <= 2048 and V_TOTAL <= 1024. Behaviour outside these limits is undefined.

Test Plan:
- Reset then en=1, run 1056*628 clk -> hs period 1056 clk with width 128; vs width 4*1056 clk; exactly one frame_trig; frame_count=1.
- Model returns colour_in = f(x,y) one clk late (e.g. {x[3:0], y[3:0], 4'hA}) -> at pixel (5,3), output two clk after x=5,y=3 is R=5,G=3,B=A; during h_cnt=800..1055 RGB=0.
- Sync alignment -> vga_hs asserts exactly 2 clk after h_cnt=840 and deasserts 2 clk after h_cnt=968; vga_vs asserts at line 601 (+2 clk); SYNC_POL=0 run inverts both.
- en dropped at (h=400, v=300) for 10 clk, then raised -> RGB=0 within 2 clk; x,y=0 while en=0; scan resumes at (0,0); no frame_trig until v reaches 600.
- rst pulsed low for 3 ns mid-line -> all outputs immediately take their reset values; frame_count=0; the next frame_trig occurs 600*1056 clk after release.
- Force frame_count to 0xFFFF (run or preload via long sim) -> next frame_trig wraps it to 0x0000.
